// File: rtl/filter_pkg.sv
// Shared definitions for the filter tap sequencer.
// State encodings, default sizes and tap indices.
package filter_pkg;

    localparam int N_DEF     = 25;
    localparam int NTAPS_DEF = 3;
    localparam int TAP_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [TAP_W-1:0] TAP_FK   = 2'd0;
    localparam logic [TAP_W-1:0] TAP_FK_1 = 2'd1;
    localparam logic [TAP_W-1:0] TAP_FK_2 = 2'd2;

endpackage

// File: rtl/filter_sequencer.sv
// Sequences delay-line shift and MAC tap selection per input sample,
// then presents the result with a valid/ready handshake.
module filter_sequencer
    import filter_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int NTAPS = NTAPS_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic        out_ready,
    input  logic        ovr_clr,
    output logic        shift,
    output logic [1:0]  tap_sel,
    output logic        acc_clr,
    output logic        acc_en,
    output logic        out_valid,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] frame_cnt
);

    localparam int CW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NTAPS - 1);

    if (N < 1) begin : g_bad_n
        $error("filter_sequencer: N must be at least 1");
    end
    if (NTAPS < 1 || NTAPS > 4) begin : g_bad_ntaps
        $error("filter_sequencer: NTAPS must be 1..4");
    end

    state_t        state;
    logic [CW-1:0] cnt;
    logic          hs;
    logic          drop;

    assign hs   = (state == ST_DONE) && out_ready;
    assign drop = sample_valid &&
                  ((state == ST_SHIFT) || (state == ST_TAP) ||
                   ((state == ST_DONE) && !out_ready));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            shift     <= 1'b0;
            tap_sel   <= TAP_FK;
            acc_clr   <= 1'b0;
            acc_en    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            // a drop in the same cycle as a clear keeps the flag set
            overrun <= drop | (overrun & ~ovr_clr);
            if (hs) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (sample_valid) begin
                        state <= ST_SHIFT;
                        shift <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    state   <= ST_TAP;
                    cnt     <= '0;
                    shift   <= 1'b0;
                    tap_sel <= TAP_FK;
                    acc_clr <= 1'b1;
                    acc_en  <= 1'b1;
                end
                ST_TAP: begin
                    acc_clr <= 1'b0;
                    if (cnt == LAST) begin
                        state     <= ST_DONE;
                        cnt       <= '0;
                        acc_en    <= 1'b0;
                        tap_sel   <= TAP_FK;
                        out_valid <= 1'b1;
                    end else begin
                        cnt     <= cnt + CW'(1);
                        tap_sel <= TAP_W'(cnt + CW'(1));
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (sample_valid) begin
                            state <= ST_SHIFT;
                            shift <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_sequencer.sv
// Directed bench for filter_sequencer: cycle-exact latency, handshake,
// overrun, reset abort and frame counter wrap.
module tb_filter_sequencer;

    logic        clk;
    logic        rst_n;
    logic        sample_valid;
    logic        out_ready;
    logic        ovr_clr;
    logic        shift;
    logic [1:0]  tap_sel;
    logic        acc_clr;
    logic        acc_en;
    logic        out_valid;
    logic        busy;
    logic        overrun;
    logic [15:0] frame_cnt;

    int compared   = 0;
    int mismatched = 0;
    int shifts     = 0;
    logic [15:0] fcnt = 16'd0;

    // {shift, tap_sel, acc_clr, acc_en, out_valid, busy} in cycles 1..6
    localparam logic [6:0] SEQ [0:5] = '{
        7'b1000001,
        7'b0001101,
        7'b0010101,
        7'b0100101,
        7'b0000011,
        7'b0000000
    };

    filter_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .out_ready    (out_ready),
        .ovr_clr      (ovr_clr),
        .shift        (shift),
        .tap_sel      (tap_sel),
        .acc_clr      (acc_clr),
        .acc_en       (acc_en),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun),
        .frame_cnt    (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && shift === 1'b1) shifts++;
    end

    function automatic logic [6:0] vec();
        return {shift, tap_sel, acc_clr, acc_en, out_valid, busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sample_valid = 1'b0;
        out_ready = 1'b0;
        ovr_clr = 1'b0;
        tick();
        tick();
        compared++;
        if (vec() !== 7'b0) begin
            mismatched++;
            $display("FAIL reset_outs: got %b want %b", vec(), 7'b0);
        end
        compared++;
        if ({overrun, frame_cnt} !== 17'b0) begin
            mismatched++;
            $display("FAIL reset_cnt: got ovr=%b cnt=%h want 0/0000",
                     overrun, frame_cnt);
        end
        rst_n = 1'b1;
        fcnt = 16'd0;
        tick();
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            compared++;
            if (vec() !== SEQ[i]) begin
                mismatched++;
                $display("FAIL single_c%0d: got %b want %b",
                         i + 1, vec(), SEQ[i]);
            end
            if (i < 5) tick();
        end
        fcnt++;
        compared++;
        if (frame_cnt !== fcnt || overrun !== 1'b0) begin
            mismatched++;
            $display("FAIL single_cnt: got %h/%b want %h/0",
                     frame_cnt, overrun, fcnt);
        end
    endtask

    task automatic test_backpressure();
        int s0;
        out_ready = 1'b0;
        s0 = shifts;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (out_valid !== 1'b1 || shift !== 1'b0 ||
                frame_cnt !== fcnt) begin
                mismatched++;
                $display("FAIL bp_hold%0d: got v=%b s=%b cnt=%h want 1/0/%h",
                         k, out_valid, shift, frame_cnt, fcnt);
            end
            sample_valid = (k == 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        fcnt++;
        compared++;
        if ({out_valid, busy, overrun} !== 3'b001 || frame_cnt !== fcnt) begin
            mismatched++;
            $display("FAIL bp_done: got v/b/o=%b%b%b cnt=%h want 001 %h",
                     out_valid, busy, overrun, frame_cnt, fcnt);
        end
        compared++;
        if (shifts - s0 !== 1) begin
            mismatched++;
            $display("FAIL bp_shifts: got %0d want 1", shifts - s0);
        end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        compared++;
        if (overrun !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_clr: got %b want 0", overrun);
        end
    endtask

    task automatic test_overrun();
        int s0;
        out_ready = 1'b1;
        s0 = shifts;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        tick();
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        compared++;
        if (overrun !== 1'b1 || tap_sel !== 2'd2) begin
            mismatched++;
            $display("FAIL ovr_set: got o=%b tap=%0d want 1/2",
                     overrun, tap_sel);
        end
        tick();
        tick();
        fcnt++;
        compared++;
        if (frame_cnt !== fcnt || shifts - s0 !== 1) begin
            mismatched++;
            $display("FAIL ovr_frame: got cnt=%h shifts=%0d want %h/1",
                     frame_cnt, shifts - s0, fcnt);
        end
        repeat (4) tick();
        compared++;
        if (overrun !== 1'b1) begin
            mismatched++;
            $display("FAIL ovr_sticky: got %b want 1", overrun);
        end
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        compared++;
        if (overrun !== 1'b0) begin
            mismatched++;
            $display("FAIL ovr_clear: got %b want 0", overrun);
        end
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        sample_valid = 1'b1;
        ovr_clr = 1'b1;
        tick();
        sample_valid = 1'b0;
        ovr_clr = 1'b0;
        compared++;
        if (overrun !== 1'b1) begin
            mismatched++;
            $display("FAIL ovr_setwins: got %b want 1", overrun);
        end
        repeat (3) tick();
        fcnt++;
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        compared++;
        if (overrun !== 1'b0 || busy !== 1'b0 || frame_cnt !== fcnt) begin
            mismatched++;
            $display("FAIL ovr_end: got o=%b b=%b cnt=%h want 0/0/%h",
                     overrun, busy, frame_cnt, fcnt);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        repeat (4) tick();
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        fcnt++;
        compared++;
        if ({shift, out_valid, busy, overrun} !== 4'b1010 ||
            frame_cnt !== fcnt) begin
            mismatched++;
            $display("FAIL b2b_shift: got s/v/b/o=%b%b%b%b cnt=%h want 1010 %h",
                     shift, out_valid, busy, overrun, frame_cnt, fcnt);
        end
        repeat (4) tick();
        compared++;
        if (out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_valid2: got %b want 1", out_valid);
        end
        tick();
        fcnt++;
        compared++;
        if (frame_cnt !== fcnt || busy !== 1'b0 || overrun !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_end: got cnt=%h b=%b o=%b want %h/0/0",
                     frame_cnt, busy, overrun, fcnt);
        end
    endtask

    task automatic test_reset_mid_tap();
        int s0;
        out_ready = 1'b1;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        fcnt = 16'd0;
        compared++;
        if (vec() !== 7'b0 || overrun !== 1'b0 || frame_cnt !== 16'd0) begin
            mismatched++;
            $display("FAIL rst_tap: got %b o=%b cnt=%h want 0000000/0/0000",
                     vec(), overrun, frame_cnt);
        end
        rst_n = 1'b1;
        s0 = shifts;
        for (int c = 0; c < 5; c++) begin
            tick();
            compared++;
            if ({shift, acc_en, out_valid} !== 3'b0 || frame_cnt !== 16'd0) begin
                mismatched++;
                $display("FAIL rst_quiet%0d: got s/e/v=%b%b%b cnt=%h want 000/0",
                         c, shift, acc_en, out_valid, frame_cnt);
            end
        end
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        compared++;
        if (shift !== 1'b1 || shifts - s0 !== 0) begin
            mismatched++;
            $display("FAIL rst_first: got s=%b extra=%0d want 1/0",
                     shift, shifts - s0);
        end
        repeat (5) tick();
        fcnt++;
        compared++;
        if (frame_cnt !== fcnt) begin
            mismatched++;
            $display("FAIL rst_frame: got %h want %h", frame_cnt, fcnt);
        end
    endtask

    task automatic test_wrap();
        force dut.frame_cnt = 16'hFFFE;
        #1;
        release dut.frame_cnt;
        fcnt = 16'hFFFE;
        out_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            sample_valid = 1'b1;
            tick();
            sample_valid = 1'b0;
            repeat (5) tick();
            fcnt++;
            compared++;
            if (frame_cnt !== fcnt) begin
                mismatched++;
                $display("FAIL wrap%0d: got %h want %h", f, frame_cnt, fcnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_reset_mid_tap();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/filter_sequencer.md
FILTER_SEQUENCER -- requirements
Module: filter_sequencer

Interface
REQ-001 The parameter N SHALL default to 25 and set the datapath word width to 2*N; it is carried for width checks only and no port depends on it.
REQ-002 The parameter NTAPS SHALL default to 3 and give the number of delay-line taps sequenced per sample (fk, fk_1, fk_2).
REQ-003 Port clk  input  1  SHALL be the single rising-edge clock.
REQ-004 Port rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-005 Port sample_valid  input  1  SHALL be a one-cycle strobe meaning a new input sample is present on the delay-line input.
REQ-006 Port out_ready  input  1  SHALL mean the downstream consumer accepts the result.
REQ-007 Port ovr_clr  input  1  SHALL clear the sticky overrun flag.
REQ-008 Port shift  output  1  SHALL be a registered one-cycle pulse that drives the delay-line shift strobe.
REQ-009 Port tap_sel  output  2  SHALL select the tap for the MAC: 0 = fk, 1 = fk_1, 2 = fk_2.
REQ-010 Port acc_clr  output  1  SHALL load the accumulator with the current product instead of adding it to the accumulator.
REQ-011 Port acc_en  output  1  SHALL enable the accumulator update in the same cycle.
REQ-012 Port out_valid  output  1  SHALL mean the filter result is valid.
REQ-013 Port busy  output  1  SHALL be high in every state except IDLE.
REQ-014 Port overrun  output  1  SHALL be a sticky flag set when a sample is dropped.
REQ-015 Port frame_cnt  output  16  SHALL count completed output handshakes.

Function
REQ-016 The FSM SHALL have the states IDLE, SHIFT, TAP, and DONE, plus a tap counter of width clog2(NTAPS).
REQ-017 In IDLE, sample_valid=1 SHALL move the FSM to SHIFT on the next edge; sample_valid=0 SHALL keep it in IDLE.
REQ-018 In SHIFT, shift SHALL be 1 for exactly one cycle, and the FSM SHALL then go to TAP with the tap counter at 0.
REQ-019 In TAP, tap_sel SHALL equal the tap counter and acc_en SHALL be 1; acc_clr SHALL be 1 only when the tap counter is 0; the counter SHALL increment each cycle; after tap NTAPS-1 the FSM SHALL go to DONE.
REQ-020 In DONE, out_valid SHALL be 1 and SHALL hold until out_ready=1; the handshake SHALL complete in the cycle where out_valid=1 and out_ready=1.
REQ-021 When the handshake completes, frame_cnt SHALL increment by 1 and wrap from 0xFFFF to 0x0000.
REQ-022 On handshake with sample_valid=0, the FSM SHALL go to IDLE; on handshake with sample_valid=1 in the same cycle, the sample SHALL be accepted and the FSM SHALL go directly to SHIFT without setting overrun.
REQ-023 A sample_valid=1 in SHIFT, in TAP, or in DONE without a handshake SHALL drop the sample, set overrun, and leave the FSM unchanged.
REQ-024 ovr_clr=1 SHALL clear overrun on the next edge; if ovr_clr and a drop occur in the same cycle, the set SHALL win.
REQ-025 Latency SHALL be fixed: sample_valid at edge t gives shift high in cycle t+1, taps in cycles t+2..t+1+NTAPS, and out_valid from t+2+NTAPS (t+5 for NTAPS=3).
REQ-026 All outputs SHALL be registered; shift, acc_clr, and acc_en SHALL be glitch-free and never high outside the states listed above.
REQ-027 tap_sel SHALL be 0 whenever the FSM is not in TAP.

Reset
REQ-028 With rst_n=0 at a clock edge, the FSM SHALL go to IDLE, the tap counter SHALL be 0, and shift, acc_clr, acc_en, out_valid, busy, overrun, tap_sel, and frame_cnt SHALL all be 0.
REQ-029 A reset asserted mid-sequence SHALL abort the sequence with no further shift or acc_en pulse, and no output handshake SHALL be generated for the aborted sample.
REQ-030 The first sample_valid after rst_n returns to 1 SHALL be handled as from IDLE.

Structure
REQ-031 The state encodings, the default N, the default NTAPS, and the tap-index constants SHALL live in the shared filter package.
REQ-032 The block SHALL be a single FSM module with no sub-module; the delay line and the MAC remain external and are driven only through shift, tap_sel, acc_clr, and acc_en.

Verification
REQ-033 Single sample, out_ready tied to 1: sample_valid at cycle 0 -> shift at 1; tap_sel 0/1/2 at 2/3/4 with acc_clr only at 2; out_valid at 5; frame_cnt=1 at 6.
REQ-034 Back-pressure: out_ready=0 for 4 cycles after out_valid -> out_valid holds 4 cycles, no extra shift, and frame_cnt increments once.
REQ-035 Overrun: second sample_valid at cycle 3 -> overrun=1 from cycle 4 and only one shift pulse; ovr_clr at cycle 10 -> overrun=0 at 11.
REQ-036 Back-to-back: sample_valid together with the DONE handshake -> shift on the next cycle, overrun stays 0, and frame_cnt increments.
REQ-037 Reset mid-TAP: rst_n=0 at cycle 3 -> all outputs 0 at cycle 4, no out_valid, and frame_cnt=0.
REQ-038 Wrap: frame_cnt preloaded through 65535 handshakes -> next handshake gives frame_cnt=0.
